// File: rtl/board_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : board_write_scheduler
// Description : Serialises every board tile RAM write for Pac-Man and the four
//               ghosts. Each tick erases all five old blocks, draws all five
//               new blocks (pac last), then commits locations together and
//               flags Pac-Man/ghost collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module board_write_scheduler #(
  parameter int ADDR_W      = 10,
  parameter int TYPE_W      = 4,
  parameter int MAX_ADDR    = 767,
  parameter int EMPTY_TILE  = 0,
  parameter int PAC_TILE    = 2,
  parameter int BLINKY_TILE = 3,
  parameter int CLYDE_TILE  = 4,
  parameter int INKY_TILE   = 5,
  parameter int PINKY_TILE  = 6,
  parameter int PAC_INIT    = 561,
  parameter int BLINKY_INIT = 303,
  parameter int CLYDE_INIT  = 335,
  parameter int INKY_INIT   = 334,
  parameter int PINKY_INIT  = 336
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick,
  input  logic [ADDR_W-1:0] pac_next,
  input  logic [ADDR_W-1:0] blinky_next,
  input  logic [ADDR_W-1:0] clyde_next,
  input  logic [ADDR_W-1:0] inky_next,
  input  logic [ADDR_W-1:0] pinky_next,
  output logic [ADDR_W-1:0] pac_loc,
  output logic [ADDR_W-1:0] blinky_loc,
  output logic [ADDR_W-1:0] clyde_loc,
  output logic [ADDR_W-1:0] inky_loc,
  output logic [ADDR_W-1:0] pinky_loc,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [TYPE_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              tick_overrun
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ERASE  = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);
  localparam logic [TYPE_W-1:0] EMPTY_T = TYPE_W'(EMPTY_TILE);

  // Entity index k: 0 pac, 1 blinky, 2 clyde, 3 inky, 4 pinky
  function automatic logic [TYPE_W-1:0] tile_of(input logic [2:0] k);
    case (k)
      3'd1:    tile_of = TYPE_W'(BLINKY_TILE);
      3'd2:    tile_of = TYPE_W'(CLYDE_TILE);
      3'd3:    tile_of = TYPE_W'(INKY_TILE);
      3'd4:    tile_of = TYPE_W'(PINKY_TILE);
      default: tile_of = TYPE_W'(PAC_TILE);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] init_of(input logic [2:0] k);
    case (k)
      3'd1:    init_of = ADDR_W'(BLINKY_INIT);
      3'd2:    init_of = ADDR_W'(CLYDE_INIT);
      3'd3:    init_of = ADDR_W'(INKY_INIT);
      3'd4:    init_of = ADDR_W'(PINKY_INIT);
      default: init_of = ADDR_W'(PAC_INIT);
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] loc_q    [5];
  logic [ADDR_W-1:0] loc_d    [5];
  logic [ADDR_W-1:0] shadow_q [5];
  logic [ADDR_W-1:0] shadow_d [5];
  logic [ADDR_W-1:0] next_w   [5];
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [TYPE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              collision_q, collision_d;
  logic              overrun_q, overrun_d;
  logic              hit;

  assign next_w[0] = pac_next;
  assign next_w[1] = blinky_next;
  assign next_w[2] = clyde_next;
  assign next_w[3] = inky_next;
  assign next_w[4] = pinky_next;

  // Sequencer: next-state, write port and commit/collision logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    loc_d       = loc_q;
    shadow_d    = shadow_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_q != S_IDLE);
    collision_d = collision_q;
    overrun_d   = overrun_q | (tick & (state_q != S_IDLE));
    hit         = 1'b0;
    case (state_q)
      S_INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = init_of(k_q);
        wr_data_d = tile_of(k_q);
        if (k_q == 3'd0) state_d = S_IDLE;
        else             k_d     = k_q - 3'd1;
      end
      S_IDLE: begin
        if (tick) begin
          // Out-of-range proposals keep the entity where it is
          for (int i = 0; i < 5; i++)
            shadow_d[i] = (next_w[i] > MAX_A) ? loc_q[i] : next_w[i];
          k_d     = 3'd0;
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = loc_q[k_q];
        wr_data_d = EMPTY_T;
        if (k_q == 3'd4) state_d = S_DRAW;
        else             k_d     = k_q + 3'd1;
      end
      S_DRAW: begin
        // Descending order so pac overwrites any ghost sharing its block
        wr_en_d   = 1'b1;
        wr_addr_d = shadow_q[k_q];
        wr_data_d = tile_of(k_q);
        if (k_q == 3'd0) state_d = S_COMMIT;
        else             k_d     = k_q - 3'd1;
      end
      S_COMMIT: begin
        for (int g = 1; g < 5; g++)
          hit = hit | (shadow_q[0] == shadow_q[g])
                    | ((shadow_q[0] == loc_q[g]) & (shadow_q[g] == loc_q[0]));
        collision_d = collision_q | hit;
        loc_d       = shadow_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset restarts the INIT draw sequence
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_INIT;
      k_q         <= 3'd4;
      for (int i = 0; i < 5; i++) begin
        loc_q[i]    <= init_of(3'(i));
        shadow_q[i] <= init_of(3'(i));
      end
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      loc_q       <= loc_d;
      shadow_q    <= shadow_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pac_loc      = loc_q[0];
  assign blinky_loc   = loc_q[1];
  assign clyde_loc    = loc_q[2];
  assign inky_loc     = loc_q[3];
  assign pinky_loc    = loc_q[4];
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_en        = wr_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign collision    = collision_q;
  assign tick_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_board_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_write_scheduler
// Description : Self-checking bench for board_write_scheduler. Round vectors
//               come from a table; the expected RAM write stream is queued
//               when stimulus is driven and popped as wr_en pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_write_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       tick     = 1'b0;
  logic [9:0] nxt [5];
  logic [9:0] loc_o [5];
  logic [9:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_en, busy, done, collision, tick_overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0] a;
    logic [3:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct packed {
    logic [4:0][9:0] nx;
    logic [4:0][9:0] lc;
    logic            coll;
    logic            ovr;
    logic [3:0]      retick;
    logic            rst;
  } vec_t;
  vec_t vecs[8];

  int TILE [5] = '{2, 3, 4, 5, 6};
  int INITL[5] = '{561, 303, 335, 334, 336};
  int model_loc[5];

  always #10 CLOCK_50 = ~CLOCK_50;

  board_write_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .tick        (tick),
    .pac_next    (nxt[0]),
    .blinky_next (nxt[1]),
    .clyde_next  (nxt[2]),
    .inky_next   (nxt[3]),
    .pinky_next  (nxt[4]),
    .pac_loc     (loc_o[0]),
    .blinky_loc  (loc_o[1]),
    .clyde_loc   (loc_o[2]),
    .inky_loc    (loc_o[3]),
    .pinky_loc   (loc_o[4]),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done),
    .collision   (collision),
    .tick_overrun(tick_overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the head of the queue
  always @(negedge CLOCK_50) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(wr_addr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e.a));
        chk("wr_data", int'(wr_data), int'(e.d));
      end
    end
  end

  // Test process moves just after the monitor's sampling point
  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  function automatic vec_t mk(input int p, b, c, i, k, lp, lb, lc, li, lk,
                              input bit coll, ovr, input int rt, input bit rst);
    vec_t v;
    v.nx[0] = 10'(p);  v.nx[1] = 10'(b);  v.nx[2] = 10'(c);
    v.nx[3] = 10'(i);  v.nx[4] = 10'(k);
    v.lc[0] = 10'(lp); v.lc[1] = 10'(lb); v.lc[2] = 10'(lc);
    v.lc[3] = 10'(li); v.lc[4] = 10'(lk);
    v.coll = coll; v.ovr = ovr; v.retick = 4'(rt); v.rst = rst;
    return v;
  endfunction

  // Reset for two edges, then check reset state and the INIT draw sequence
  task automatic apply_reset();
    exp_q.delete();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk("rst_loc", int'(loc_o[i]), INITL[i]);
      model_loc[i] = INITL[i];
    end
    for (int i = 4; i >= 0; i--) exp_q.push_back({10'(INITL[i]), 4'(TILE[i])});
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("init_wr_en", int'(wr_en), (c <= 5) ? 1 : 0);
      chk("init_busy", int'(busy), (c <= 5) ? 1 : 0);
      chk("init_done", int'(done), 0);
    end
    chk("init_queue_left", exp_q.size(), 0);
  endtask

  // Queue the 5 erases and 5 draws a round must produce
  task automatic push_round(input vec_t v);
    for (int i = 0; i < 5; i++) exp_q.push_back({10'(model_loc[i]), 4'd0});
    for (int i = 4; i >= 0; i--) begin
      int d;
      d = (int'(v.nx[i]) > 767) ? model_loc[i] : int'(v.nx[i]);
      exp_q.push_back({10'(d), 4'(TILE[i])});
    end
  endtask

  task automatic run_round(input vec_t v);
    if (v.rst) apply_reset();
    push_round(v);
    for (int i = 0; i < 5; i++) nxt[i] = v.nx[i];
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == int'(v.retick)) begin
        tick = 1'b1;
        for (int i = 0; i < 5; i++) nxt[i] = 10'd5;
      end else begin
        tick = 1'b0;
      end
      chk("round_wr_en", int'(wr_en), (c <= 10) ? 1 : 0);
      chk("round_done", int'(done), (c == 11) ? 1 : 0);
      chk("round_busy", int'(busy), (c <= 11) ? 1 : 0);
      if (c == 11) begin
        for (int i = 0; i < 5; i++) chk("commit_loc", int'(loc_o[i]), int'(v.lc[i]));
        chk("commit_collision", int'(collision), int'(v.coll));
      end
      if (c == 12) begin
        chk("round_overrun", int'(tick_overrun), int'(v.ovr));
        chk("round_queue_left", exp_q.size(), 0);
      end
    end
    for (int i = 0; i < 5; i++) model_loc[i] = int'(v.lc[i]);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) nxt[i] = 10'(INITL[i]);
    vecs[0] = mk(900, 303, 335, 334, 336, 561, 303, 335, 334, 336, 0, 0, 0, 1);
    vecs[1] = mk(562, 303, 335, 334, 336, 562, 303, 335, 334, 336, 0, 0, 0, 0);
    vecs[2] = mk(100, 101, 335, 334, 336, 100, 101, 335, 334, 336, 0, 0, 0, 0);
    vecs[3] = mk(101, 100, 335, 334, 336, 101, 100, 335, 334, 336, 1, 0, 0, 0);
    vecs[4] = mk(400, 400, 335, 334, 336, 400, 400, 335, 334, 336, 1, 0, 0, 1);
    vecs[5] = mk(401, 400, 335, 334, 336, 401, 400, 335, 334, 336, 1, 0, 0, 0);
    vecs[6] = mk(562, 303, 335, 334, 336, 562, 303, 335, 334, 336, 0, 1, 4, 1);
    vecs[7] = mk(561, 303, 335, 334, 336, 561, 303, 335, 334, 336, 0, 1, 10, 1);

    for (int n = 0; n < 8; n++) run_round(vecs[n]);

    // Abort: reset sampled at T+7 after six writes of a round
    apply_reset();
    begin
      vec_t v;
      v = mk(562, 303, 335, 334, 336, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push_round(v);
      for (int i = 0; i < 5; i++) nxt[i] = v.nx[i];
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("abort_done", int'(done), 0);
      chk("abort_wr_en", int'(wr_en), 1);
    end
    chk("abort_queue_left", exp_q.size(), 4);
    apply_reset();
    chk("abort_pac_loc", int'(loc_o[0]), 561);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_write_scheduler.md
# board_write_scheduler

Sequences all writes into the shared 768-entry board tile RAM (32×24 blocks, 4-bit tile codes) on behalf of Pac-Man and the four ghosts. On each game tick it captures every entity's proposed next block and erases all five old positions. It then draws all five new positions through the single RAM write port, commits the location registers together and flags Pac-Man/ghost collisions. It sits between the per-entity behavior blocks and the board RAM write port; the VGA read path is not touched.

## Interface

Parameters:
- ADDR_W, 10, block address width (address = block_y*32 + block_x)
- TYPE_W, 4, tile code width
- MAX_ADDR, 767, highest legal block address
- EMPTY_TILE, 0, code written to a vacated block
- PAC_TILE, 2; BLINKY_TILE, 3; CLYDE_TILE, 4; INKY_TILE, 5; PINKY_TILE, 6: entity tile codes
- PAC_INIT, 561; BLINKY_INIT, 303; CLYDE_INIT, 335; INKY_INIT, 334; PINKY_INIT, 336: reset locations

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle pulse requesting an update round
- pac_next, blinky_next, clyde_next, inky_next, pinky_next  in  ADDR_W each  proposed next block per entity
- pac_loc, blinky_loc, clyde_loc, inky_loc, pinky_loc  out  ADDR_W each  committed location registers
- wr_addr  out  ADDR_W  board RAM write address
- wr_data  out  TYPE_W  board RAM write data
- wr_en  out  1  board RAM write enable
- busy  out  1  high while initialising or in a round
- done  out  1  one-cycle pulse when a round commits
- collision  out  1  sticky; Pac-Man met a ghost
- tick_overrun  out  1  sticky; tick arrived while busy

## Operation

- States: INIT, IDLE, ERASE, DRAW, COMMIT. A 3-bit entity index k (0..4) selects the entity.
- Entity order k = 0..4 is pac, blinky, clyde, inky, pinky.
- INIT (entered on reset): one write per cycle, 5 cycles.
  - Draw order k = 4 down to 0; each writes the entity tile at its INIT location.
  - Then go to IDLE.
- IDLE: on tick, latch all five *_next into shadow registers, set k = 0 and go to ERASE.
- Next-location sanitising at latch time: a value > MAX_ADDR is replaced by that entity's current *_loc, i.e. the entity does not move.
- ERASE: write EMPTY_TILE to *_loc[k], k = 0..4. After k = 4, set k = 4 and go to DRAW.
- DRAW: write the entity tile to shadow[k], k = 4 down to 0, so pac is drawn last and wins a shared block. After k = 0, go to COMMIT.
  - All erases precede all draws, so overlapping entities never erase each other.
- COMMIT:
  - All five *_loc load from shadow simultaneously.
  - done = 1.
  - collision is set if, for any ghost g, shadow_pac == shadow_g, or (shadow_pac == g_loc and shadow_g == pac_loc) (swap).
  - Then go to IDLE.
- Unchanged entities are still erased and redrawn; there is no skip logic.
- A tick while busy is ignored and sets tick_overrun; shadows are not touched.
- tick in the COMMIT cycle is also ignored and counts as an overrun.
- collision and tick_overrun clear only on reset.

## Timing

- Reset values: *_loc = *_INIT, wr_en = 0, wr_addr = 0, wr_data = 0, done = 0, collision = 0, tick_overrun = 0. busy = 1 in the cycle after reset, because INIT begins.
- INIT: wr_en is high for the 5 cycles after reset deasserts. busy falls in the following cycle.
- All outputs are registered. If tick is sampled at edge T:
  - wr_en is high for cycles T+1..T+10: 5 erases, then 5 draws.
  - COMMIT occurs in cycle T+11: done = 1, the new *_loc are visible and collision is updated.
  - busy is high for T+1..T+11; IDLE is reached at T+12.
- Round latency is 11 cycles from tick to done. The minimum tick spacing is 12 cycles.
- *_next is sampled only at the tick edge; changes during a round have no effect.
- Reset mid-round aborts immediately:
  - no commit and no done;
  - *_loc return to INIT and INIT redraws.
  - Erased tiles from the aborted round are not restored.

## Test plan

- Reset release -> 5 consecutive writes (336←6, 334←5, 335←4, 303←3, 561←2), then busy = 0, and all *_loc equal their INIT values.
- tick with pac_next = 562 and all other ghosts' next equal to their current loc:
  - writes at T+1..T+10 are EMPTY to 561, 303, 335, 334, 336, then 336←6, 334←5, 335←4, 303←3, 562←2;
  - done at T+11; pac_loc = 562; collision = 0.
- pac_next = 900 (out of range) -> pac redrawn at 561, pac_loc stays 561.
- Pac-Man moves onto the block blinky also moves onto:
  - pac_next = blinky_next = 400;
  - block 400 is written 3 and then 2 (pac last);
  - collision = 1 at T+11 and remains 1 across later rounds.
- Swap: pac at 100, blinky at 101; pac_next = 101, blinky_next = 100 -> collision = 1.
- tick repeated at T+5 -> ignored, tick_overrun = 1, the round completes normally at T+11.
- reset asserted at T+7 -> no done pulse, locations revert to INIT, the INIT write sequence is observed.
